// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: FSM encodings, default limits and the address map shared by the
// system-bus arbiter and its address decoder.
package bus_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int DEF_TIMEOUT  = 16;
    localparam int DEF_MAX_LOCK = 8;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] top;
    } addr_range_t;

    localparam addr_range_t DM_RANGE     = '{base: 32'h0000_0000, top: 32'h0000_2fff};
    localparam addr_range_t TIMER0_RANGE = '{base: 32'h0000_7f00, top: 32'h0000_7f0f};
    localparam addr_range_t TIMER1_RANGE = '{base: 32'h0000_7f10, top: 32'h0000_7f1f};

    function automatic logic in_range(input addr_range_t r, input logic [31:0] addr);
        return addr >= r.base && addr <= r.top;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: two-way round-robin picker; on a tie the master that did not win last
// time is chosen, and the last-winner register updates whenever a grant is taken.
module bus_rr_pick (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] win
);
    // last = 1 out of reset so master 0 wins the very first tie
    logic last;

    always_comb win = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;

    always_ff @(posedge clk) begin
        if (reset) last <= 1'b1;
        else if (take) last <= win[1];
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin system-bus arbiter with burst lock and a
// per-transaction timeout so a hung slave cannot stall the pipeline.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_req,
    input  logic [1:0]  m_lock,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    input  logic [7:0]  m_byteen,
    output logic [1:0]  m_gnt,
    output logic [1:0]  m_done,
    output logic [1:0]  m_err,
    output logic [31:0] m_rdata,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int LW = $clog2(MAX_LOCK) + 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);
    localparam logic [LW-1:0] LOCK_SAT  = LW'(MAX_LOCK);

    logic [0:0]    state;
    logic [1:0]    gnt;
    logic [1:0]    win;
    logic [TW-1:0] tmo_cnt;
    logic [LW-1:0] lock_cnt;
    logic          g;
    logic          busy;
    logic          own_req;
    logic          done;
    logic          err;
    logic          stay;

    bus_rr_pick u_pick (
        .clk   (clk),
        .reset (reset),
        .req   (m_req),
        .take  (!busy && |m_req),
        .win   (win)
    );

    always_comb begin
        g       = gnt[1];
        busy    = state == ST_BUSY;
        own_req = m_req[g];
        done    = busy && own_req && (bus_ready || tmo_cnt == TMO_LAST);
        err     = busy && own_req && !bus_ready && tmo_cnt == TMO_LAST;
        // keep the bus only while the other master has not waited out the lock budget
        stay    = m_lock[g] && (lock_cnt < LOCK_LAST || !m_req[~g]);
    end

    assign m_gnt      = gnt;
    assign m_done     = done ? gnt : 2'b00;
    assign m_err      = err ? gnt : 2'b00;
    assign m_rdata    = (done && !err) ? bus_rdata : 32'h0;
    assign bus_valid  = busy && own_req;
    assign bus_addr   = g ? m_addr[63:32] : m_addr[31:0];
    assign bus_wdata  = g ? m_wdata[63:32] : m_wdata[31:0];
    assign bus_byteen = (bus_valid && !err) ? (g ? m_byteen[7:4] : m_byteen[3:0]) : 4'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            gnt      <= 2'b00;
            tmo_cnt  <= '0;
            lock_cnt <= '0;
        end else if (!busy) begin
            if (|m_req) begin
                state    <= ST_BUSY;
                gnt      <= win;
                tmo_cnt  <= '0;
                lock_cnt <= '0;
            end
        end else if (!own_req || err || (bus_ready && !stay)) begin
            state   <= ST_IDLE;
            gnt     <= 2'b00;
            tmo_cnt <= '0;
        end else if (bus_ready) begin
            tmo_cnt <= '0;
            if (lock_cnt != LOCK_SAT) lock_cnt <= lock_cnt + 1'b1;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
endmodule
